call_conditioner: RTL and testbench
===================================

CALL_CONDITIONER -- requirements
Module: call_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive disagreeing cycles before a debounced output changes; legal range 2..65535.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 BTN  input  3  raw floor call buttons; bit k-1 is floor k; asynchronous, bouncing.
REQ-005 FC_RAW  input  3  raw limit switches; bit k-1 is floor k; asynchronous, bouncing.
REQ-006 P  output  3  one-hot request to the lift controller (bit0=P1, bit1=P2, bit2=P3); at most one bit high.
REQ-007 FC  output  3  debounced limit switches to the lift controller.
REQ-008 PEND  output  3  bitmap of floors currently queued.
REQ-009 COUNT  output  2  number of queued requests, 0..3.

Function
REQ-010 Each of the 6 raw inputs SHALL pass through its own 2-flop synchronizer.
REQ-011 Each synchronized input SHALL have its own debounce counter, 16 bits wide, and a stable value.
REQ-012 Debounce: counter clears when the synchronized value equals the stable value; otherwise the counter increments; at DEBOUNCE_CYCLES-1 with disagreement still present, the stable value is updated and the counter clears.
REQ-013 Raw-to-stable latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges for a clean step; a pulse shorter than DEBOUNCE_CYCLES cycles SHALL produce no change.
REQ-014 FC SHALL equal the debounced limit-switch stable values, registered.
REQ-015 A call event for floor k SHALL be a 0->1 transition of the debounced BTN[k-1], one cycle wide, detected from a registered copy.
REQ-016 Request queue: 3-entry FIFO of 2-bit floor IDs (1..3), order of arrival preserved, with the PEND bitmap and COUNT maintained alongside.
REQ-017 A push of floor k SHALL be dropped when PEND[k-1]=1 (duplicate), or when COUNT=0 and FC[k-1]=1 (lift already there).
REQ-018 Several call events in one cycle SHALL be pushed in ascending floor order in that same edge.
REQ-019 Pop: when COUNT>0 and FC of the head floor is 1, the head is removed and its PEND bit cleared.
REQ-020 Push and pop in the same cycle SHALL both take effect; a push of the floor being popped in that cycle is dropped.
REQ-021 Queue overflow cannot occur (3 distinct floors, 3 entries); a 4th push condition is unreachable and SHALL leave state unchanged.
REQ-022 P SHALL be registered: one-hot of the head floor when COUNT>0, else 3'b000; it updates one edge after the queue changes.
REQ-023 End-to-end latency from a clean raw button step (queue empty, lift elsewhere) to P high is DEBOUNCE_CYCLES+4 rising edges.

Reset
REQ-024 While RESET=1 at a rising edge: synchronizers, stable values, registered copies and counters SHALL clear to 0.
REQ-025 While RESET=1 at a rising edge: queue SHALL empty, with P=000, FC=000, PEND=000, COUNT=0 from that edge.
REQ-026 RESET asserted mid-operation SHALL discard all pending requests; no call event SHALL be generated for a button already held at reset release until it is debounced high from 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 After reset, BTN=010 held -> P=010 first seen after edge 8, PEND=010, COUNT=1.
REQ-028 BTN[1] high for 3 cycles then low -> P, PEND, COUNT stay 0.
REQ-029 BTN3 pressed, then BTN2 pressed, FC=001 -> P=100 and COUNT=2; FC_RAW=100 held -> after debounce P=010 and COUNT=1.
REQ-030 BTN2 pressed twice, no FC2 -> COUNT=1, PEND=010.
REQ-031 FC debounced 001, queue empty, BTN1 pressed -> no push, P=000.
REQ-032 COUNT=2 then RESET for 1 cycle -> next edge P=000, PEND=000, COUNT=0.

Source files
------------

// File: rtl/call_conditioner.sv
// Lift call conditioner: synchronizes and debounces floor buttons and limit switches,
// then queues floor calls in arrival order and presents the head as a one-hot request.
module call_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] BTN,
  input  logic [2:0] FC_RAW,
  output logic [2:0] P,
  output logic [2:0] FC,
  output logic [2:0] PEND,
  output logic [1:0] COUNT
);

  localparam int unsigned NIN = 6;
  localparam int unsigned NF  = 3;
  localparam int unsigned CW  = 16;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sync1;
  logic [NIN-1:0] sync2;
  logic [NIN-1:0] stab;
  logic [CW-1:0]  cnt [NIN];
  logic [NF-1:0]  btn_q;
  logic [NF-1:0]  call;

  logic [1:0]     q   [NF];
  logic [1:0]     q_n [NF];
  logic [1:0]     count_n;
  logic [NF-1:0]  pend_n;
  logic [NF-1:0]  head_oh;
  logic [NF-1:0]  p_n;
  logic           pop;

  // Floor ID (1..3) to one-hot bitmap; 0 maps to no floor.
  function automatic logic [NF-1:0] floor_oh(input logic [1:0] f);
    case (f)
      2'd1:    floor_oh = 3'b001;
      2'd2:    floor_oh = 3'b010;
      2'd3:    floor_oh = 3'b100;
      default: floor_oh = 3'b000;
    endcase
  endfunction

  assign raw = {FC_RAW, BTN};

  // Two-flop synchronizers for all six raw inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: stable value follows only after a full run of disagreement.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stab <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stab[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stab[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_q <= '0;
      FC    <= '0;
    end else begin
      btn_q <= stab[NF-1:0];
      FC    <= stab[NIN-1:NF];
    end
  end

  assign call = stab[NF-1:0] & ~btn_q;

  // Queue update: pop first, then pushes in ascending floor order; checks use pre-edge state.
  always_comb begin
    q_n     = q;
    count_n = COUNT;
    pend_n  = PEND;
    head_oh = floor_oh(q[0]);
    pop     = (COUNT != 2'd0) && ((FC & head_oh) != 3'b000);
    p_n     = (COUNT != 2'd0) ? head_oh : 3'b000;
    if (pop) begin
      q_n[0]  = q[1];
      q_n[1]  = q[2];
      q_n[2]  = 2'd0;
      count_n = COUNT - 2'd1;
      pend_n  = PEND & ~head_oh;
    end
    for (int k = 0; k < NF; k++) begin
      if (call[k] && !PEND[k] && !((COUNT == 2'd0) && FC[k]) && (count_n != 2'd3)) begin
        for (int s = 0; s < NF; s++) begin
          if (2'(s) == count_n) q_n[s] = 2'(k + 1);
        end
        count_n   = count_n + 2'd1;
        pend_n[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < NF; s++) q[s] <= 2'd0;
      COUNT <= 2'd0;
      PEND  <= '0;
      P     <= '0;
    end else begin
      q     <= q_n;
      COUNT <= count_n;
      PEND  <= pend_n;
      P     <= p_n;
    end
  end

endmodule

// File: tb/tb_call_conditioner.sv
// Bench for call_conditioner: directed vector table, hand-written corner sequences,
// and randomized bouncing inputs checked every cycle against a queue-based model.
module tb_call_conditioner;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] fc_raw;
  logic [2:0] p;
  logic [2:0] fc;
  logic [2:0] pend;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;
  bit auto_chk = 1'b0;

  always #5 clk = ~clk;

  call_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK(clk), .RESET(rst), .BTN(btn), .FC_RAW(fc_raw),
    .P(p), .FC(fc), .PEND(pend), .COUNT(count)
  );

  // Reference model state: raw delay line, run-length debounce, floor queue.
  logic [5:0] m_d1, m_d2, m_stab;
  int         m_run [6];
  logic [2:0] m_prev, m_fc, m_p;
  int         m_q [$];

  function automatic logic [2:0] floor_bit(input int f);
    return 3'(1 << (f - 1));
  endfunction

  function automatic logic [2:0] q_bits();
    logic [2:0] b = 3'b000;
    foreach (m_q[i]) b = b | floor_bit(m_q[i]);
    return b;
  endfunction

  task automatic model_step();
    logic [2:0] ev;
    logic [2:0] pend_o;
    int         cnt0;
    logic [5:0] raw;
    raw = {fc_raw, btn};
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stab = '0;
      m_prev = '0; m_fc = '0; m_p = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_q.delete();
      return;
    end
    ev     = m_stab[2:0] & ~m_prev;
    pend_o = q_bits();
    cnt0   = m_q.size();
    m_p    = (cnt0 > 0) ? floor_bit(m_q[0]) : 3'b000;
    if (cnt0 > 0 && m_fc[m_q[0] - 1]) m_q.delete(0);
    for (int k = 1; k <= 3; k++)
      if (ev[k-1] && !pend_o[k-1] && !(cnt0 == 0 && m_fc[k-1]) && m_q.size() < 3)
        m_q.push_back(k);
    m_fc   = m_stab[5:3];
    m_prev = m_stab[2:0];
    for (int i = 0; i < 6; i++) begin
      if (m_d2[i] !== m_stab[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_stab[i] = m_d2[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (auto_chk) begin
      check("model_p", p, m_p);
      check("model_fc", fc, m_fc);
      check("model_pend", pend, q_bits());
      check("model_count", {1'b0, count}, 3'(m_q.size()));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [2:0] fcr;
    int         hold;
    logic [2:0] p;
    logic [2:0] pend;
    logic [1:0] cnt;
    logic [2:0] fc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{3'b000, 3'b000, 10, 3'b000, 3'b000, 2'd0, 3'b000};
    tbl[1]  = '{3'b000, 3'b001, 10, 3'b000, 3'b000, 2'd0, 3'b001};
    tbl[2]  = '{3'b001, 3'b001, 10, 3'b000, 3'b000, 2'd0, 3'b001};
    tbl[3]  = '{3'b000, 3'b001, 10, 3'b000, 3'b000, 2'd0, 3'b001};
    tbl[4]  = '{3'b100, 3'b001, 10, 3'b100, 3'b100, 2'd1, 3'b001};
    tbl[5]  = '{3'b110, 3'b001, 10, 3'b100, 3'b110, 2'd2, 3'b001};
    tbl[6]  = '{3'b000, 3'b100, 12, 3'b010, 3'b010, 2'd1, 3'b100};
    tbl[7]  = '{3'b010, 3'b100, 10, 3'b010, 3'b010, 2'd1, 3'b100};
    tbl[8]  = '{3'b000, 3'b010, 12, 3'b000, 3'b000, 2'd0, 3'b010};
    tbl[9]  = '{3'b011, 3'b010, 10, 3'b001, 3'b001, 2'd1, 3'b010};
    tbl[10] = '{3'b000, 3'b001, 12, 3'b000, 3'b000, 2'd0, 3'b001};
    tbl[11] = '{3'b000, 3'b000, 10, 3'b000, 3'b000, 2'd0, 3'b000};
    tbl[12] = '{3'b111, 3'b000, 10, 3'b001, 3'b111, 2'd3, 3'b000};
    tbl[13] = '{3'b111, 3'b001, 12, 3'b010, 3'b110, 2'd2, 3'b001};
    tbl[14] = '{3'b000, 3'b000, 10, 3'b010, 3'b110, 2'd2, 3'b000};

    rst = 1'b1; btn = '0; fc_raw = '0;
    step(2);
    rst = 1'b0;
    check("reset_p", p, 3'b000);
    check("reset_pend", pend, 3'b000);
    check("reset_count", {1'b0, count}, 3'b000);
    check("reset_fc", fc, 3'b000);
    auto_chk = 1'b1;

    for (int i = 0; i < 15; i++) begin
      btn = tbl[i].btn;
      fc_raw = tbl[i].fcr;
      step(tbl[i].hold);
      check($sformatf("vec%0d_p", i), p, tbl[i].p);
      check($sformatf("vec%0d_pend", i), pend, tbl[i].pend);
      check($sformatf("vec%0d_count", i), {1'b0, tbl[i].cnt[1:0]}, {1'b0, count});
      check($sformatf("vec%0d_fc", i), fc, tbl[i].fc);
    end

    // Mid-operation reset with two requests queued.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("midreset_p", p, 3'b000);
    check("midreset_pend", pend, 3'b000);
    check("midreset_count", {1'b0, count}, 3'b000);
    check("midreset_fc", fc, 3'b000);

    // Clean press latency: P first high on edge DC+4 after the step.
    step(12);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    btn = 3'b010;
    step(DC + 3);
    check("latency_early_p", p, 3'b000);
    step(1);
    check("latency_p", p, 3'b010);
    check("latency_pend", pend, 3'b010);
    check("latency_count", {1'b0, count}, 3'b001);

    // Button held through reset: call regenerated once re-debounced from 0.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("held_reset_count", {1'b0, count}, 3'b000);
    step(DC + 3);
    check("held_early_p", p, 3'b000);
    step(1);
    check("held_p", p, 3'b010);

    // Glitch shorter than the debounce window is ignored.
    btn = 3'b000;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    btn = 3'b010;
    step(DC - 1);
    btn = 3'b000;
    step(12);
    check("glitch_p", p, 3'b000);
    check("glitch_pend", pend, 3'b000);
    check("glitch_count", {1'b0, count}, 3'b000);

    // Randomized bouncing buttons and switches with occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      btn    = 3'($urandom);
      fc_raw = 3'($urandom);
      rst    = ($urandom_range(0, 59) == 0);
      step(rst ? 1 : int'($urandom_range(1, 3 * DC)));
      rst = 1'b0;
    end
    step(3);

    auto_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
